// File: rtl/brick_mem_arbiter.sv
// Arbiter for the single-port brick-health RAM. It shares the RAM between the collision,
// damage and redraw requesters, maps pixel coordinates to cells, and runs the level-load fill.
module brick_mem_arbiter #(
  parameter int COLS       = 20,
  parameter int ROWS       = 8,
  parameter int XSHIFT     = 5,
  parameter int YSHIFT     = 4,
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              col_req,
  input  logic [9:0]        col_x,
  input  logic [9:0]        col_y,
  output logic              col_valid,
  output logic [9:0]        col_brickx,
  output logic [9:0]        col_bricky,
  output logic [1:0]        col_health,
  input  logic              dmg_req,
  input  logic [9:0]        dmg_x,
  input  logic [9:0]        dmg_y,
  output logic              dmg_done,
  output logic [1:0]        dmg_health,
  input  logic              drw_req,
  input  logic [9:0]        drw_x,
  input  logic [9:0]        drw_y,
  output logic              drw_valid,
  output logic [1:0]        drw_health,
  input  logic              init_go,
  input  logic [1:0]        init_health,
  output logic              init_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [1:0]        ram_wdata,
  input  logic [1:0]        ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DATA, S_WR, S_INIT} state_t;
  typedef enum logic [1:0] {ID_COL, ID_DMG, ID_DRW} id_t;

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [9:0]        COLS_W     = 10'(COLS);
  localparam logic [9:0]        ROWS_W     = 10'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'({10'd0, y >> YSHIFT} * {10'd0, COLS_W} + {10'd0, x >> XSHIFT});
  endfunction

  state_t            state_q, state_d;
  id_t               id_q, id_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [9:0]        col_brickx_q, col_brickx_d, col_bricky_q, col_bricky_d;
  logic [1:0]        col_health_q, col_health_d;
  logic [1:0]        dmg_health_q, dmg_health_d;
  logic [1:0]        drw_health_q, drw_health_d;

  logic              gnt;
  id_t               gnt_id;
  logic [9:0]        gnt_x, gnt_y;
  logic [9:0]        lat_col, lat_row;
  logic              in_field;
  logic [1:0]        rd_health;

  assign lat_col   = x_q >> XSHIFT;
  assign lat_row   = y_q >> YSHIFT;
  assign in_field  = (lat_col < COLS_W) && (lat_row < ROWS_W);
  assign rd_health = in_field ? ram_rdata : 2'd0;

  always_comb begin
    gnt    = 1'b0;
    gnt_id = ID_COL;
    gnt_x  = col_x;
    gnt_y  = col_y;
    if (starve_q == STARVE_LIM && drw_req) begin
      gnt = 1'b1; gnt_id = ID_DRW; gnt_x = drw_x; gnt_y = drw_y;
    end else if (col_req) begin
      gnt = 1'b1; gnt_id = ID_COL; gnt_x = col_x; gnt_y = col_y;
    end else if (dmg_req) begin
      gnt = 1'b1; gnt_id = ID_DMG; gnt_x = dmg_x; gnt_y = dmg_y;
    end else if (drw_req) begin
      gnt = 1'b1; gnt_id = ID_DRW; gnt_x = drw_x; gnt_y = drw_y;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    wdata_d      = '0;
    starve_d     = drw_req ? starve_q : '0;
    col_valid    = 1'b0;
    dmg_done     = 1'b0;
    drw_valid    = 1'b0;
    col_brickx_d = col_brickx_q;
    col_bricky_d = col_bricky_q;
    col_health_d = col_health_q;
    dmg_health_d = dmg_health_q;
    drw_health_d = drw_health_q;
    case (state_q)
      S_IDLE: begin
        if (init_go) begin
          state_d = S_INIT;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = init_health;
        end else if (gnt) begin
          state_d = S_RD;
          id_d    = gnt_id;
          x_d     = gnt_x;
          y_d     = gnt_y;
          addr_d  = cell_addr(gnt_x, gnt_y);
          if (gnt_id == ID_DRW) begin
            starve_d = '0;
          end else if (drw_req && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      S_RD: state_d = S_DATA;
      S_DATA: begin
        state_d = S_IDLE;
        case (id_q)
          ID_COL: begin
            col_valid    = 1'b1;
            col_health_d = rd_health;
            col_brickx_d = lat_col << XSHIFT;
            col_bricky_d = lat_row << YSHIFT;
          end
          ID_DRW: begin
            drw_valid    = 1'b1;
            drw_health_d = rd_health;
          end
          default: begin
            // Write strobe and data are registered here so they line up with S_WR;
            // a dead or out-of-field brick leaves wdata at 0 and the strobe low.
            state_d = S_WR;
            if (rd_health != 2'd0) begin
              we_d    = 1'b1;
              wdata_d = 2'(rd_health - 2'd1);
            end
          end
        endcase
      end
      S_WR: begin
        state_d      = S_IDLE;
        dmg_done     = 1'b1;
        dmg_health_d = wdata_q;
      end
      S_INIT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          we_d    = 1'b1;
          wdata_d = wdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      id_q         <= ID_COL;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      starve_q     <= '0;
      col_brickx_q <= '0;
      col_bricky_q <= '0;
      col_health_q <= '0;
      dmg_health_q <= '0;
      drw_health_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      col_brickx_q <= col_brickx_d;
      col_bricky_q <= col_bricky_d;
      col_health_q <= col_health_d;
      dmg_health_q <= dmg_health_d;
      drw_health_q <= drw_health_d;
    end
  end

  // Response data bypasses its hold register during the pulse cycle.
  assign col_brickx = col_brickx_d;
  assign col_bricky = col_bricky_d;
  assign col_health = col_health_d;
  assign dmg_health = dmg_health_d;
  assign drw_health = drw_health_d;
  assign init_busy  = (state_q == S_INIT);
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: doc/brick_mem_arbiter.md
Name: brick_mem_arbiter

Overview:
- Owns the single-port brick-state RAM: one 2-bit health value per brick cell.
- Shares the RAM among three requesters:
  - ball collision probe: read, highest priority.
  - brick damage unit: read-modify-write decrement.
  - screen redraw walker: read, lowest priority, with anti-starvation.
- Converts pixel coordinates to a RAM address and brick origin.
- Also performs the level-load fill of every cell.

Parameters:
- COLS, 20, bricks per row.
- ROWS, 8, brick rows.
- XSHIFT, 5, log2 of brick width in pixels.
- YSHIFT, 4, log2 of brick height in pixels.
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= ROWS*COLS.
- STARVE_MAX, 4, lost arbitrations after which the redraw requester is forced to win.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, reset: synchronous, active-low.
- col_req, in, 1, collision read request; level, held until col_valid.
- col_x, col_y, in, 10 each, probe pixel coordinates.
- col_valid, out, 1, one-cycle pulse: response ready.
- col_brickx, col_bricky, out, 10 each, top-left pixel of the addressed brick.
- col_health, out, 2, health of the addressed brick.
- dmg_req, in, 1, damage request; level, held until dmg_done.
- dmg_x, dmg_y, in, 10 each, pixel coordinates of the brick to damage.
- dmg_done, out, 1, one-cycle pulse: damage complete.
- dmg_health, out, 2, post-damage health.
- drw_req, in, 1, redraw read request; level.
- drw_x, drw_y, in, 10 each, pixel coordinates to read.
- drw_valid, out, 1, one-cycle pulse: response ready.
- drw_health, out, 2, health read.
- init_go, in, 1, pulse: start fill.
- init_health, in, 2, fill value.
- init_busy, out, 1, high while filling.
- ram_addr, out, ADDR_W, registered RAM address.
- ram_we, out, 1, RAM write enable.
- ram_wdata, out, 2, RAM write data.
- ram_rdata, in, 2, RAM read data, valid one cycle after ram_addr.

Behaviour:
- Address mapping:
  - col = x >> XSHIFT, row = y >> YSHIFT.
  - addr = row*COLS + col.
  - brickx = col << XSHIFT, bricky = row << YSHIFT; both truncated to 10 bits.
- Out of field: when col >= COLS or row >= ROWS:
  - No RAM write occurs.
  - The returned health is forced to 0.
  - Latency is unchanged.
- States:
  - S_IDLE → S_RD → S_DATA → S_IDLE: reads.
  - S_IDLE → S_RD → S_DATA → S_WR → S_IDLE: damage.
  - S_IDLE → S_INIT → S_IDLE: fill.
- S_IDLE arbitration, one grant per cycle:
  - init_go wins over everything.
  - Otherwise, if starve_cnt == STARVE_MAX and drw_req is high, drw wins.
  - Otherwise fixed priority: col > dmg > drw.
  - On a grant, the winner's coordinates and ID are latched and ram_addr is registered. Next state is S_RD.
- S_RD: RAM samples the address.
- S_DATA:
  - ram_rdata is valid in this state.
  - For col or drw grants: pulse the matching valid and drive data; brick origin comes from the latched coordinates.
  - Response is 2 cycles after the grant cycle.
- S_WR, damage only:
  - If read health != 0: ram_we = 1 and ram_wdata = health-1.
  - If read health == 0: ram_we stays low; never wrap to 3.
  - dmg_done pulses in S_WR; dmg_health = written value, or 0.
  - Latency is 3 cycles.
- Response outputs (col_brickx, col_bricky, col_health, dmg_health, drw_health) hold their last value. They are meaningful only with the matching pulse.
- Returning to S_IDLE: the requester must drop its req in the cycle after its pulse. A req still high in S_IDLE is treated as a new request.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each col or dmg grant while drw_req is high.
  - Clears on a drw grant or whenever drw_req is low.
- S_INIT:
  - Writes init_health to addresses 0..ROWS*COLS-1, one per cycle, with ram_we = 1.
  - init_busy is high from the cycle after init_go through the last write.
  - Requests stay pending and are not granted.
  - init_go while busy is ignored.
- Reset values:
  - State is S_IDLE.
  - All pulses are 0, ram_we = 0, init_busy = 0.
  - ram_addr = 0, ram_wdata = 0, starve_cnt = 0.
  - All response data outputs are 0.
- Reset mid-operation:
  - The in-flight transaction is abandoned; no valid or done pulse is issued.
  - RAM contents are not restored; a partial fill stays partial.

Test Plan:
1. Reset, then init_go with init_health=3:
   - init_busy is high for exactly 160 cycles and addresses 0..159 are each written once with 3.
   - Then col_req with (x=70, y=20) gives col_valid 2 cycles after the grant, with brickx=64, bricky=16, health=3, ram_addr=22.
2. dmg_req at (70,20) three times, then once more:
   - dmg_health reads 2, 1, 0, with ram_we on each of those three.
   - The fourth gives dmg_done with health 0 and no ram_we.
3. col_req, dmg_req and drw_req asserted in the same cycle:
   - Grant order is col, then dmg, then drw.
   - Each pulse arrives at its specified latency.
4. col_req held continuously, re-asserted after each valid, with drw_req high:
   - drw is granted on the arbitration after the 4th lost grant.
   - starve_cnt returns to 0.
5. Out-of-field probe col_req with (x=650, y=300):
   - col_valid arrives with health=0 and no write.
   - brickx=640 and bricky=288 as computed.
6. resetn low during S_DATA of a damage transaction and during S_INIT:
   - No dmg_done pulse; init_busy goes to 0.
   - Untouched RAM cells keep their old values.
